// File: rtl/tilt_step_gen.sv
// tilt_step_gen
//   Turns raw signed accelerometer X/Y samples into one-cycle direction step
//   pulses. It averages blocks of 2**AVG_SHIFT samples. A deadzone with
//   hysteresis holds a level board still. The tilt magnitude picks one of three
//   step rates.
//
// Ports
//   clk                        system clock
//   reset                      synchronous, active-high reset
//   accel_x / accel_y          signed tilt samples, DATA_WIDTH bits
//   accel_valid                both samples valid this cycle
//   x_increment / x_decriment  one-cycle step pulses, X axis
//   y_increment / y_decriment  one-cycle step pulses, Y axis
//   speed_x / speed_y          level: 0 idle, 1 slow, 2 medium, 3 fast
//
// Step FSM, one per axis
//   state  | meaning
//   S_IDLE | level 0, no pulses, counter held at 0
//   S_RUN  | level 1..3, counter counts up to the period top of the level
module tilt_step_gen #(
   parameter int CLK_FREQUENCY_HZ       = 100000000,
   parameter int DATA_WIDTH             = 12,
   parameter int AVG_SHIFT              = 2,
   parameter int DEADZONE               = 64,
   parameter int HYST                   = 16,
   parameter int MED_THRESH             = 256,
   parameter int FAST_THRESH            = 512,
   parameter int SLOW_HZ                = 2,
   parameter int MED_HZ                 = 5,
   parameter int FAST_HZ                = 10,
   parameter int SIMULATE               = 0,
   parameter int SIMULATE_FREQUENCY_CNT = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic signed [DATA_WIDTH-1:0] accel_x,
   input  logic signed [DATA_WIDTH-1:0] accel_y,
   input  logic                         accel_valid,
   output logic                         x_increment,
   output logic                         x_decriment,
   output logic                         y_increment,
   output logic                         y_decriment,
   output logic [1:0]                   speed_x,
   output logic [1:0]                   speed_y
);

   localparam int ACC_W  = DATA_WIDTH + AVG_SHIFT;
   localparam int SC_W   = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
   localparam int N_AVG  = 1 << AVG_SHIFT;
   localparam int T_SLOW = (SIMULATE != 0) ? 4*SIMULATE_FREQUENCY_CNT - 1 : CLK_FREQUENCY_HZ/SLOW_HZ - 1;
   localparam int T_MED  = (SIMULATE != 0) ? 2*SIMULATE_FREQUENCY_CNT - 1 : CLK_FREQUENCY_HZ/MED_HZ - 1;
   localparam int T_FAST = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT - 1   : CLK_FREQUENCY_HZ/FAST_HZ - 1;
   // The counter never passes the slowest period top.
   localparam int CNT_W  = $clog2(T_SLOW + 1);

   localparam logic [CNT_W-1:0] T_SLOW_C = CNT_W'(T_SLOW);
   localparam logic [CNT_W-1:0] T_MED_C  = CNT_W'(T_MED);
   localparam logic [CNT_W-1:0] T_FAST_C = CNT_W'(T_FAST);
   localparam logic [SC_W-1:0]  LAST_SMP = SC_W'(N_AVG - 1);

   localparam logic [DATA_WIDTH-1:0] DZ_ON   = DATA_WIDTH'(DEADZONE);
   localparam logic [DATA_WIDTH-1:0] DZ_OFF  = DATA_WIDTH'(DEADZONE - HYST);
   localparam logic [DATA_WIDTH-1:0] MED_C   = DATA_WIDTH'(MED_THRESH);
   localparam logic [DATA_WIDTH-1:0] FAST_C  = DATA_WIDTH'(FAST_THRESH);
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] MAG_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};

   typedef enum logic {S_IDLE, S_RUN} state_e;

   logic signed [DATA_WIDTH-1:0] smp      [2];
   logic signed [ACC_W-1:0]      sum_q    [2];
   logic signed [ACC_W-1:0]      sum_d    [2];
   logic signed [DATA_WIDTH-1:0] avg_q    [2];
   logic signed [DATA_WIDTH-1:0] avg_d    [2];
   logic [SC_W-1:0]              smp_cnt_q;
   logic [DATA_WIDTH-1:0]        mag      [2];
   logic [1:0]                   lvl_d    [2];
   logic                         neg_d    [2];
   state_e                       state_q  [2];
   logic [CNT_W-1:0]             cnt_q    [2];
   logic                         neg_q    [2];
   logic                         inc_q    [2];
   logic                         dec_q    [2];
   logic [1:0]                   speed_q  [2];

   assign smp[0] = accel_x;
   assign smp[1] = accel_y;

   function automatic logic [CNT_W-1:0] period_top(input logic [1:0] lvl);
      case (lvl)
         2'd1:    return T_SLOW_C;
         2'd2:    return T_MED_C;
         default: return T_FAST_C;
      endcase
   endfunction

   always_comb begin
      for (int a = 0; a < 2; a++) begin
         sum_d[a] = sum_q[a] + ACC_W'(smp[a]);
         avg_d[a] = DATA_WIDTH'(sum_d[a] >>> AVG_SHIFT);

         // The most negative value has no positive twin, so it saturates.
         if (avg_q[a] == MOST_NEG)
            mag[a] = MAG_MAX;
         else if (avg_q[a][DATA_WIDTH-1])
            mag[a] = $unsigned(-avg_q[a]);
         else
            mag[a] = $unsigned(avg_q[a]);

         neg_d[a] = avg_q[a][DATA_WIDTH-1];

         // A moving axis keeps going down to DEADZONE-HYST. An idle axis needs the full DEADZONE.
         lvl_d[a] = 2'd0;
         if ((state_q[a] == S_IDLE) ? (mag[a] >= DZ_ON) : (mag[a] >= DZ_OFF)) begin
            if (mag[a] < MED_C)
               lvl_d[a] = 2'd1;
            else if (mag[a] < FAST_C)
               lvl_d[a] = 2'd2;
            else
               lvl_d[a] = 2'd3;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         smp_cnt_q <= '0;
         for (int a = 0; a < 2; a++) begin
            sum_q[a]   <= '0;
            avg_q[a]   <= '0;
            state_q[a] <= S_IDLE;
            cnt_q[a]   <= '0;
            neg_q[a]   <= 1'b0;
            inc_q[a]   <= 1'b0;
            dec_q[a]   <= 1'b0;
            speed_q[a] <= 2'd0;
         end
      end else begin
         if (accel_valid) begin
            if (smp_cnt_q == LAST_SMP) begin
               smp_cnt_q <= '0;
               for (int a = 0; a < 2; a++) begin
                  sum_q[a] <= '0;
                  avg_q[a] <= avg_d[a];
               end
            end else begin
               smp_cnt_q <= smp_cnt_q + 1'b1;
               for (int a = 0; a < 2; a++) sum_q[a] <= sum_d[a];
            end
         end

         for (int a = 0; a < 2; a++) begin
            inc_q[a]   <= 1'b0;
            dec_q[a]   <= 1'b0;
            speed_q[a] <= lvl_d[a];
            case (state_q[a])
               S_IDLE: begin
                  cnt_q[a] <= '0;
                  if (lvl_d[a] != 2'd0) begin
                     state_q[a] <= S_RUN;
                     neg_q[a]   <= neg_d[a];
                     inc_q[a]   <= ~neg_d[a];
                     dec_q[a]   <= neg_d[a];
                  end
               end
               S_RUN: begin
                  if (lvl_d[a] == 2'd0) begin
                     state_q[a] <= S_IDLE;
                     cnt_q[a]   <= '0;
                  end else if ((neg_d[a] != neg_q[a]) || (cnt_q[a] >= period_top(lvl_d[a]))) begin
                     // A reversal restarts the period with a pulse in the new direction.
                     cnt_q[a] <= '0;
                     neg_q[a] <= neg_d[a];
                     inc_q[a] <= ~neg_d[a];
                     dec_q[a] <= neg_d[a];
                  end else begin
                     cnt_q[a] <= cnt_q[a] + 1'b1;
                  end
               end
               default: state_q[a] <= S_IDLE;
            endcase
         end
      end
   end

   assign x_increment = inc_q[0];
   assign x_decriment = dec_q[0];
   assign y_increment = inc_q[1];
   assign y_decriment = dec_q[1];
   assign speed_x     = speed_q[0];
   assign speed_y     = speed_q[1];

endmodule

// File: tb/tb_tilt_step_gen.sv
module tb_tilt_step_gen;

   logic               clk = 1'b0;
   logic               reset;
   logic               accel_valid;
   logic signed [11:0] accel_x;
   logic signed [11:0] accel_y;
   logic               x_increment, x_decriment, y_increment, y_decriment;
   logic [1:0]         speed_x, speed_y;

   always #5 clk = ~clk;

   tilt_step_gen #(.SIMULATE(1)) dut (
      .clk(clk), .reset(reset),
      .accel_x(accel_x), .accel_y(accel_y), .accel_valid(accel_valid),
      .x_increment(x_increment), .x_decriment(x_decriment),
      .y_increment(y_increment), .y_decriment(y_decriment),
      .speed_x(speed_x), .speed_y(speed_y)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference model: block averages with floor division. Pulses are scheduled
   // from the absolute cycle of the previous pulse.
   int sum_m [2];
   int avg_m [2];
   int lvl_m [2];
   int dir_m [2];
   int last_m[2];
   int cnt_m;
   int exp_inc[2], exp_dec[2], exp_spd[2];

   typedef struct {
      int x; int y;
      int sx; int sy;
      int xi; int xd; int yi; int yd;
   } vec_t;
   vec_t tbl[10];

   function automatic int period(input int l);
      if (l == 1) return 20;
      if (l == 2) return 10;
      return 5;
   endfunction

   function automatic int floor_div4(input int s);
      if (s >= 0) return s / 4;
      return -((-s + 3) / 4);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
   endtask

   task automatic model_edge(input logic r, input logic v, input int x, input int y);
      int mag, nl, nd;
      bit mov, p;
      if (r) begin
         cnt_m = 0;
         for (int a = 0; a < 2; a++) begin
            sum_m[a] = 0; avg_m[a] = 0; lvl_m[a] = 0; dir_m[a] = 1; last_m[a] = 0;
            exp_inc[a] = 0; exp_dec[a] = 0; exp_spd[a] = 0;
         end
         return;
      end
      for (int a = 0; a < 2; a++) begin
         mag = (avg_m[a] < 0) ? -avg_m[a] : avg_m[a];
         if (mag > 2047) mag = 2047;
         mov = (lvl_m[a] == 0) ? (mag >= 64) : (mag >= 48);
         nl  = !mov ? 0 : (mag < 256) ? 1 : (mag < 512) ? 2 : 3;
         nd  = (avg_m[a] < 0) ? -1 : 1;
         p   = (nl != 0) && (lvl_m[a] == 0 || nd != dir_m[a] || cyc - last_m[a] >= period(nl));
         if (p) begin
            last_m[a] = cyc;
            dir_m[a]  = nd;
         end
         exp_inc[a] = (p && nd > 0) ? 1 : 0;
         exp_dec[a] = (p && nd < 0) ? 1 : 0;
         exp_spd[a] = nl;
         lvl_m[a]   = nl;
      end
      if (v) begin
         sum_m[0] += x;
         sum_m[1] += y;
         cnt_m++;
         if (cnt_m == 4) begin
            avg_m[0] = floor_div4(sum_m[0]);
            avg_m[1] = floor_div4(sum_m[1]);
            sum_m[0] = 0; sum_m[1] = 0; cnt_m = 0;
         end
      end
   endtask

   // One clock: drive on negedge, update the model at posedge, compare 1 ns later.
   task automatic step(input logic r, input logic v, input int x, input int y);
      @(negedge clk);
      reset = r; accel_valid = v; accel_x = 12'(x); accel_y = 12'(y);
      @(posedge clk);
      cyc++;
      model_edge(r, v, x, y);
      #1;
      check("model_outputs",
            {24'd0, x_increment, x_decriment, y_increment, y_decriment, speed_x, speed_y},
            {24'd0, exp_inc[0][0], exp_dec[0][0], exp_inc[1][0], exp_dec[1][0],
             exp_spd[0][1:0], exp_spd[1][1:0]});
   endtask

   task automatic feed4(input int x, input int y);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, x, y);
   endtask

   int p1, p2, p3, n_xi, n_xd, n_yi, n_yd, n_diag;

   initial begin
      reset = 1'b1; accel_valid = 1'b0; accel_x = '0; accel_y = '0;
      step(1'b1, 1'b0, 0, 0);
      step(1'b1, 1'b0, 0, 0);
      check("reset_speed_x", speed_x, 0);
      check("reset_pulses", {x_increment, x_decriment, y_increment, y_decriment}, 0);

      // Level board: two full averages of zero.
      n_xi = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 0, 0);
         n_xi += x_increment + x_decriment + y_increment + y_decriment;
      end
      step(1'b0, 1'b0, 0, 0);
      check("level_no_pulse", n_xi, 0);
      check("level_speed", {speed_x, speed_y}, 0);

      // Slow +X: pulses 1, 21, 41 cycles after the averaging edge.
      feed4(100, 0);
      p1 = -1; p2 = -1; p3 = -1; n_xi = 0; n_yi = 0;
      for (int i = 1; i <= 45; i++) begin
         step(1'b0, 1'b0, 0, 0);
         if (i == 1) check("slow_speed_x", speed_x, 1);
         if (x_increment) begin
            n_xi++;
            if (n_xi == 1) p1 = i; else if (n_xi == 2) p2 = i; else if (n_xi == 3) p3 = i;
         end
         n_yi += y_increment + y_decriment + x_decriment;
      end
      check("slow_first", p1, 1);
      check("slow_second", p2, 21);
      check("slow_third", p3, 41);
      check("slow_other_silent", n_yi, 0);

      // Reversal to fast -X while running slow.
      feed4(-600, 0);
      p1 = -1; p2 = -1; n_xd = 0; n_xi = 0;
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 1'b0, 0, 0);
         if (x_decriment) begin
            n_xd++;
            if (n_xd == 1) p1 = i; else if (n_xd == 2) p2 = i;
         end
         n_xi += x_increment;
      end
      check("rev_first", p1, 1);
      check("rev_second", p2, 6);
      check("rev_count", n_xd, 3);
      check("rev_no_inc", n_xi, 0);
      check("rev_speed", speed_x, 3);

      // Hysteresis 70 -> 55 -> 40.
      step(1'b1, 1'b0, 0, 0);
      feed4(70, 0);
      step(1'b0, 1'b0, 0, 0);
      check("hyst70_speed", speed_x, 1);
      feed4(55, 0);
      n_xi = 0;
      for (int i = 0; i < 25; i++) begin
         step(1'b0, 1'b0, 0, 0);
         if (i == 0) check("hyst55_speed", speed_x, 1);
         n_xi += x_increment;
      end
      check("hyst55_pulsing", (n_xi > 0) ? 1 : 0, 1);
      feed4(40, 0);
      n_xi = 0;
      for (int i = 0; i < 25; i++) begin
         step(1'b0, 1'b0, 0, 0);
         if (i == 0) check("hyst40_speed", speed_x, 0);
         n_xi += x_increment + x_decriment;
      end
      check("hyst40_stopped", n_xi, 0);

      // Diagonal medium.
      step(1'b1, 1'b0, 0, 0);
      feed4(300, -300);
      n_diag = 0; n_xi = 0;
      for (int i = 1; i <= 25; i++) begin
         step(1'b0, 1'b0, 0, 0);
         if (i == 1) check("diag_speeds", {speed_x, speed_y}, 4'b1010);
         if (x_increment && y_decriment) n_diag++;
         n_xi += x_increment;
      end
      check("diag_coincide", n_diag, 3);
      check("diag_x_count", n_xi, 3);

      // Reset mid-run with a partial average pending.
      step(1'b0, 1'b1, 600, 0);
      step(1'b0, 1'b1, 600, 0);
      step(1'b1, 1'b1, 600, 0);
      check("midreset_outputs",
            {x_increment, x_decriment, y_increment, y_decriment, speed_x, speed_y}, 0);
      n_xi = 0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 600, 0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 0, 0);
         n_xi += x_increment + speed_x;
      end
      check("midreset_partial", n_xi, 0);
      step(1'b0, 1'b1, 600, 0);
      step(1'b0, 1'b0, 0, 0);
      check("midreset_fresh_speed", speed_x, 3);
      check("midreset_fresh_pulse", x_increment, 1);

      // Table of single-average cases: first cycle after the averaging edge.
      tbl[0] = '{0,     0,    0, 0, 0, 0, 0, 0};
      tbl[1] = '{100,   0,    1, 0, 1, 0, 0, 0};
      tbl[2] = '{-600,  0,    3, 0, 0, 1, 0, 0};
      tbl[3] = '{300,  -300,  2, 2, 1, 0, 0, 1};
      tbl[4] = '{63,   -64,   0, 1, 0, 0, 0, 1};
      tbl[5] = '{255,   256,  1, 2, 1, 0, 1, 0};
      tbl[6] = '{511,   512,  2, 3, 1, 0, 1, 0};
      tbl[7] = '{-2048, 0,    3, 0, 0, 1, 0, 0};
      tbl[8] = '{2047, -1,    3, 0, 1, 0, 0, 0};
      tbl[9] = '{-47,   47,   0, 0, 0, 0, 0, 0};
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b0, 0, 0);
         feed4(tbl[k].x, tbl[k].y);
         step(1'b0, 1'b0, 0, 0);
         check($sformatf("tbl%0d_speed_x", k), speed_x, tbl[k].sx);
         check($sformatf("tbl%0d_speed_y", k), speed_y, tbl[k].sy);
         check($sformatf("tbl%0d_pulses", k),
               {x_increment, x_decriment, y_increment, y_decriment},
               {tbl[k].xi[0], tbl[k].xd[0], tbl[k].yi[0], tbl[k].yd[0]});
      end

      // Random phases against the model.
      step(1'b1, 1'b0, 0, 0);
      for (int ph = 0; ph < 60; ph++) begin
         int bx, by, len, sx, sy;
         bx  = ($urandom_range(0, 9) == 0) ? -2048 : int'($urandom_range(0, 1400)) - 700;
         by  = int'($urandom_range(0, 1400)) - 700;
         len = $urandom_range(20, 80);
         for (int i = 0; i < len; i++) begin
            sx = bx + int'($urandom_range(0, 16)) - 8;
            sy = by + int'($urandom_range(0, 16)) - 8;
            if (sx < -2048) sx = -2048;
            if (sx > 2047)  sx = 2047;
            if (sy < -2048) sy = -2048;
            if (sy > 2047)  sy = 2047;
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), sx, sy);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
